// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid-buffered pipeline register with flush and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]    bubble_q, bubble_d;
    logic                in_ready_q, out_valid_q;
    logic                in_fire, out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        bubble_d    = (out_ready && !out_valid_q && bubble_q != '1) ? bubble_q + 1'b1 : bubble_q;
        case (state_q)
            EMPTY: if (in_fire) begin
                main_data_d = in_data;
                main_ctrl_d = in_ctrl;
                state_d     = ONE;
            end
            ONE: if (in_fire && out_fire) begin
                main_data_d = in_data;
                main_ctrl_d = in_ctrl;
            end else if (in_fire) begin
                skid_data_d = in_data;
                skid_ctrl_d = in_ctrl;
                state_d     = FULL;
            end else if (out_fire) begin
                state_d = EMPTY;
            end
            FULL: if (out_fire) begin
                main_data_d = skid_data_q;
                main_ctrl_d = skid_ctrl_q;
                state_d     = ONE;
            end
            default: state_d = EMPTY;
        endcase
        // a killed entry is never re-presented, so flush only needs to empty the state
        if (flush) state_d = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            bubble_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            bubble_q    <= bubble_d;
            in_ready_q  <= state_d != FULL;
            out_valid_q <= state_d != EMPTY;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = main_data_q;
    assign out_ctrl   = out_valid_q ? main_ctrl_q : '0;
    assign occupancy  = state_q;
    assign bubble_cnt = bubble_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg against a queue model.
module tb_pipe_stage_reg;
    logic        clk = 0, clr = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [95:0] in_data = '0;
    logic [23:0] in_ctrl = '0;
    logic        in_ready, out_valid, s_in_ready, s_out_valid;
    logic [95:0] out_data, s_out_data;
    logic [23:0] out_ctrl, s_out_ctrl;
    logic [1:0]  occupancy, s_occupancy;
    logic [15:0] bubble_cnt;
    logic [2:0]  s_bubble_cnt;

    logic [95:0] qd[$];
    logic [23:0] qc[$];
    int          mb16 = 0, mb3 = 0;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.CNT_W(3)) dut_s (
        .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_ctrl(s_out_ctrl), .occupancy(s_occupancy), .bubble_cnt(s_bubble_cnt)
    );

    // reference: FIFO of at most two entries, updated at each rising edge
    task automatic tick();
        bit ir, ov;
        @(posedge clk);
        ir = qd.size() < 2;
        ov = qd.size() > 0;
        if (clr) begin
            qd.delete(); qc.delete(); mb16 = 0; mb3 = 0;
        end else begin
            if (out_ready && !ov) begin
                mb16 = (mb16 == 65535) ? mb16 : mb16 + 1;
                mb3  = (mb3 == 7) ? mb3 : mb3 + 1;
            end
            if (flush) begin
                qd.delete(); qc.delete();
            end else begin
                if (ov && out_ready) begin void'(qd.pop_front()); void'(qc.pop_front()); end
                if (in_valid && ir) begin qd.push_back(in_data); qc.push_back(in_ctrl); end
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input bit r, input logic [95:0] d);
        in_valid = v; out_ready = r; in_data = d;
        in_ctrl = 24'($urandom) | 24'h1;
    endtask

    task automatic test_reset();
        clr = 1; drive(0, 0, '0); tick(); clr = 0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        checks++; if (out_ctrl !== 24'h0) begin failures++; $display("FAIL reset_out_ctrl got=%h exp=0", out_ctrl); end
        checks++; if (bubble_cnt !== 16'd0 || s_bubble_cnt !== 3'd0) begin failures++; $display("FAIL reset_bubble got=%0d/%0d exp=0/0", bubble_cnt, s_bubble_cnt); end
    endtask

    task automatic test_pass_through();
        logic [95:0] v[3] = '{96'h11, 96'h22, 96'h33};
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, v[i]); tick();
            checks++; if (out_valid !== 1'b1 || out_data !== v[i] || out_ctrl !== qc[0]) begin
                failures++; $display("FAIL pass_data[%0d] got=%h/%h exp=%h/%h", i, out_data, out_ctrl, v[i], qc[0]); end
            checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL pass_occ[%0d] got=%0d exp=1", i, occupancy); end
        end
        drive(0, 1, '0); tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL pass_drain got=%b/%0d exp=0/0", out_valid, occupancy); end
    endtask

    task automatic test_stall_fill();
        drive(1, 0, 96'hA); tick();
        drive(1, 0, 96'hB); tick();
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin failures++; $display("FAIL stall_full got=%0d/%b exp=2/0", occupancy, in_ready); end
        drive(1, 0, 96'hC); tick();
        checks++; if (occupancy !== 2'd2 || out_data !== 96'hA) begin failures++; $display("FAIL stall_hold got=%0d/%h exp=2/a", occupancy, out_data); end
        out_ready = 1; tick();
        checks++; if (out_data !== 96'hB || in_ready !== 1'b1) begin failures++; $display("FAIL stall_b got=%h/%b exp=b/1", out_data, in_ready); end
        tick();
        checks++; if (out_data !== 96'hC || occupancy !== 2'd1) begin failures++; $display("FAIL stall_c got=%h/%0d exp=c/1", out_data, occupancy); end
        in_valid = 0; tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        drive(1, 0, 96'h1); tick();
        drive(1, 0, 96'h2); tick();
        flush = 1; drive(1, 1, 96'h3); tick(); flush = 0;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 24'h0) begin
            failures++; $display("FAIL flush_empty got=%0d/%b/%h exp=0/0/0", occupancy, out_valid, out_ctrl); end
        drive(0, 0, '0); tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_absent got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_bubble();
        clr = 1; drive(0, 0, '0); tick(); clr = 0;
        out_ready = 1;
        repeat (5) tick();
        checks++; if (bubble_cnt !== 16'd5 || s_bubble_cnt !== 3'd5) begin failures++; $display("FAIL bubble_5 got=%0d/%0d exp=5/5", bubble_cnt, s_bubble_cnt); end
        repeat (10) tick();
        checks++; if (bubble_cnt !== 16'd15 || s_bubble_cnt !== 3'd7) begin failures++; $display("FAIL bubble_sat got=%0d/%0d exp=15/7", bubble_cnt, s_bubble_cnt); end
        out_ready = 0; flush = 1; tick(); flush = 0;
        checks++; if (bubble_cnt !== 16'd15 || s_bubble_cnt !== 3'd7) begin failures++; $display("FAIL bubble_flush got=%0d/%0d exp=15/7", bubble_cnt, s_bubble_cnt); end
    endtask

    task automatic test_clr_mid();
        drive(1, 0, 96'h5); tick();
        drive(1, 0, 96'h6); tick();
        clr = 1; drive(1, 1, 96'h7); tick(); clr = 0;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 24'h0 || in_ready !== 1'b1 || bubble_cnt !== 16'd0) begin
            failures++; $display("FAIL clr_mid got=%0d/%b/%h/%b/%0d exp=0/0/0/1/0", occupancy, out_valid, out_ctrl, in_ready, bubble_cnt); end
        drive(1, 0, 96'hABC); tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 96'hABC || occupancy !== 2'd1) begin
            failures++; $display("FAIL clr_push got=%b/%h/%0d exp=1/abc/1", out_valid, out_data, occupancy); end
        drive(0, 1, '0); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_alone got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        logic [23:0] ec;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), {$urandom, $urandom, $urandom});
            flush = ($urandom_range(0, 19) == 0);
            clr = ($urandom_range(0, 59) == 0);
            tick();
            ec = qd.size() > 0 ? qc[0] : 24'h0;
            checks++; if (in_ready !== (qd.size() < 2) || out_valid !== (qd.size() > 0) || occupancy !== 2'(qd.size())) begin
                failures++; $display("FAIL rand_state[%0d] got=%b/%b/%0d exp_occ=%0d", i, in_ready, out_valid, occupancy, qd.size()); end
            checks++; if (out_ctrl !== ec || (qd.size() > 0 && out_data !== qd[0])) begin
                failures++; $display("FAIL rand_data[%0d] got=%h/%h exp_ctrl=%h", i, out_data, out_ctrl, ec); end
            checks++; if (bubble_cnt !== 16'(mb16) || s_bubble_cnt !== 3'(mb3)) begin
                failures++; $display("FAIL rand_bubble[%0d] got=%0d/%0d exp=%0d/%0d", i, bubble_cnt, s_bubble_cnt, mb16, mb3); end
        end
        flush = 0; clr = 0;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_stall_fill();
        test_flush();
        test_bubble();
        test_clr_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 96, SHALL set the datapath payload width (operand words plus extend value).
REQ-002 Parameter CTRL_W, default 24, SHALL set the control payload width (write enables, ALU control, cond, flags, register addresses).
REQ-003 Parameter CNT_W, default 16, SHALL set the bubble-counter width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; clock and reset ports are named as follows.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 clr  input  1  synchronous active-high reset.
REQ-007 flush  input  1  synchronous discard of all held entries (branch/hazard kill).
REQ-008 in_valid  input  1  upstream entry present.
REQ-009 in_ready  output  1  stage can accept; registered, depends only on state.
REQ-010 in_data  input  DATA_W  upstream datapath payload.
REQ-011 in_ctrl  input  CTRL_W  upstream control payload.
REQ-012 out_valid  output  1  entry presented downstream.
REQ-013 out_ready  input  1  downstream accepts (0 = stall).
REQ-014 out_data  output  DATA_W  head-entry datapath payload.
REQ-015 out_ctrl  output  CTRL_W  head-entry control payload, all-zero when out_valid=0.
REQ-016 occupancy  output  2  entries held (0, 1 or 2).
REQ-017 bubble_cnt  output  CNT_W  saturating count of downstream-ready cycles with no valid output.

Function
REQ-018 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-019 Storage SHALL be two entries: main (head) and skid; states EMPTY (occupancy 0), ONE (1), FULL (2).
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL.
REQ-021 out_valid SHALL be 1 in ONE and FULL; out_data/out_ctrl SHALL come from main.
REQ-022 out_ctrl SHALL be forced to zero whenever out_valid=0 (bubble never carries write enables); out_data is don't-care then.
REQ-023 EMPTY: in_fire -> main<=input, go to ONE; otherwise stay.
REQ-024 ONE: in_fire & out_fire -> main<=input, stay ONE; in_fire only -> skid<=input, go to FULL; out_fire only -> go to EMPTY; neither -> hold.
REQ-025 FULL: out_fire -> main<=skid, go to ONE; otherwise hold both entries unchanged.
REQ-026 Latency SHALL be 1 cycle: an entry accepted at edge N appears on out_* after edge N when no older entry precedes it.
REQ-027 Ordering SHALL be strictly FIFO; no entry is dropped or duplicated except by flush/clr.
REQ-028 Throughput SHALL be one entry per cycle under continuous in_valid=1 and out_ready=1.
REQ-029 flush=1 SHALL force state EMPTY at the next edge, discarding main, skid and any same-cycle input, even if in_fire or out_fire is asserted.
REQ-030 out_fire during a flush cycle SHALL still count as consumed by downstream; the stage does not re-present it.
REQ-031 bubble_cnt SHALL increment when out_ready=1 and out_valid=0, saturate at all-ones, and be unaffected by flush.
REQ-032 clr SHALL take priority over flush and all handshake activity.

Reset
REQ-033 On clr=1 at a rising edge: state EMPTY, occupancy=0, out_valid=0, out_ctrl=0, in_ready=1, bubble_cnt=0; main/skid contents cleared to zero.
REQ-034 clr asserted mid-operation (any state) SHALL apply REQ-033 at that edge, discarding held entries.

Verification
REQ-035 Pass-through: out_ready=1, push A=0x11,B=0x22,C=0x33 back-to-back -> out shows A,B,C on consecutive cycles 1 cycle after each accept; occupancy stays 1.
REQ-036 Stall fill: out_ready=0, push A,B -> occupancy 2, in_ready=0 at cycle 3, C held upstream; release out_ready -> A,B,C delivered in order, none lost.
REQ-037 Flush while FULL with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, pushed entry absent from output.
REQ-038 Bubble counter: out_ready=1, in_valid=0 for 5 cycles -> bubble_cnt=5; with CNT_W=3, 10 idle cycles -> bubble_cnt=7 (saturated); flush leaves it unchanged.
REQ-039 clr mid-stall in FULL -> next cycle all REQ-033 values, then a new push X appears alone on out one cycle later.
